// File: rtl/lm_channel_mux.sv
// Multi-channel LED manager: per-channel last-value/sticky registers, one paged channel on the data LEDs, blinking pending flags.
// Inputs reach the LEDs two cycles later and there is no backpressure. Define LM_SCROLL_EN to build the auto-scroll pager.
module lm_channel_mux #(
  parameter int NUM_CH      = 4,
  parameter int CH_WIDTH    = 8,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_LOG2  = 24,
  localparam int PW         = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH-1:0]            ch_sticky,
  input  logic [PW-1:0]                page_sel,
  input  logic                         auto_scroll,
  input  logic                         clear,
  output logic [NUM_CH+CH_WIDTH-1:0]   leds,
  output logic [PW-1:0]                page_cur
);

  typedef enum logic {ST_MANUAL, ST_SCROLL} state_t;

  state_t                     state_q, state_d;
  logic [CH_WIDTH-1:0]        val_q [NUM_CH];
  logic [CH_WIDTH-1:0]        val_d [NUM_CH];
  logic [NUM_CH-1:0]          pend_q, pend_d;
  logic [PW-1:0]              cur_q, cur_d;
  logic [PW-1:0]              page_lim;
  logic [BLINK_LOG2-1:0]      blink_q;
  logic [NUM_CH-1:0]          status;
  logic [NUM_CH+CH_WIDTH-1:0] leds_q, leds_d;
  logic [PW-1:0]              page_cur_q;

`ifdef LM_SCROLL_EN
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] rr_next;
  logic [PW-1:0] rr_idx;
`else
  logic unused_auto_scroll;
  assign unused_auto_scroll = auto_scroll;
`endif

  assign page_lim = (int'(page_sel) > NUM_CH - 1) ? PW'(NUM_CH - 1) : page_sel;

  // Clear is applied before the update so a same-cycle write lands on a zeroed register.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      val_d[i]  = val_q[i];
      pend_d[i] = pend_q[i];
      if (clear && (cur_q == PW'(i))) begin
        val_d[i]  = '0;
        pend_d[i] = 1'b0;
      end
      if (ch_valid[i]) begin
        if (ch_sticky[i]) begin
          val_d[i] = val_d[i] | ch_data[i*CH_WIDTH +: CH_WIDTH];
        end else begin
          val_d[i] = ch_data[i*CH_WIDTH +: CH_WIDTH];
        end
        pend_d[i] = (val_d[i] != '0);
      end
    end
  end

`ifdef LM_SCROLL_EN
  // Descending walk so the nearest pending channel after cur wins.
  always_comb begin
    rr_next = cur_q;
    rr_idx  = '0;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      rr_idx = PW'((int'(cur_q) + k) % NUM_CH);
      if (pend_q[rr_idx]) begin
        rr_next = rr_idx;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
`ifdef LM_SCROLL_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      ST_SCROLL: begin
`ifdef LM_SCROLL_EN
        if (!auto_scroll) begin
          state_d = ST_MANUAL;
        end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          hold_d = '0;
          cur_d  = rr_next;
        end else begin
          hold_d = hold_q + HW'(1);
        end
`else
        state_d = ST_MANUAL;
`endif
      end
      default: begin
`ifdef LM_SCROLL_EN
        if (auto_scroll) begin
          state_d = ST_SCROLL;
          hold_d  = '0;
        end else begin
          cur_d = page_lim;
        end
`else
        cur_d = page_lim;
`endif
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      status[i] = pend_q[i] & (blink_q[BLINK_LOG2-1] | (cur_q == PW'(i)));
    end
  end

  assign leds_d = {status, val_q[cur_q]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        val_q[i] <= '0;
      end
      pend_q     <= '0;
      cur_q      <= '0;
      state_q    <= ST_MANUAL;
      blink_q    <= '0;
      leds_q     <= '0;
      page_cur_q <= '0;
`ifdef LM_SCROLL_EN
      hold_q     <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        val_q[i] <= val_d[i];
      end
      pend_q     <= pend_d;
      cur_q      <= cur_d;
      state_q    <= state_d;
      blink_q    <= blink_q + BLINK_LOG2'(1);
      leds_q     <= leds_d;
      page_cur_q <= cur_q;
`ifdef LM_SCROLL_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign leds     = leds_q;
  assign page_cur = page_cur_q;

endmodule
